// File: rtl/fp_adder_arbiter_if.sv
// rtl/fp_adder_arbiter_if.sv - requester, response and adder-side signals of the shared FP adder arbiter
interface fp_adder_arbiter_if #(
   parameter int W = 32
);
   logic         req0_valid;
   logic         req0_ready;
   logic [W-1:0] req0_a;
   logic [W-1:0] req0_b;
   logic         req1_valid;
   logic         req1_ready;
   logic [W-1:0] req1_a;
   logic [W-1:0] req1_b;
   logic         resp_valid;
   logic         resp_ready;
   logic         resp_id;
   logic [W-1:0] resp_result;
   logic         resp_overflow;
   logic         resp_error;
   logic         busy;
   logic         add_enable;
   logic         add_load;
   logic [W-1:0] add_a;
   logic [W-1:0] add_b;
   logic [W-1:0] add_result;
   logic         add_done;
   logic         add_overflow;

   modport slave (
      input  req0_valid, req0_a, req0_b,
      input  req1_valid, req1_a, req1_b,
      input  resp_ready,
      input  add_result, add_done, add_overflow,
      output req0_ready, req1_ready,
      output resp_valid, resp_id, resp_result, resp_overflow, resp_error,
      output busy, add_enable, add_load, add_a, add_b
   );

   modport master (
      output req0_valid, req0_a, req0_b,
      output req1_valid, req1_a, req1_b,
      output resp_ready,
      output add_result, add_done, add_overflow,
      input  req0_ready, req1_ready,
      input  resp_valid, resp_id, resp_result, resp_overflow, resp_error,
      input  busy, add_enable, add_load, add_a, add_b
   );
endinterface

// File: rtl/fp_adder_arbiter.sv
// rtl/fp_adder_arbiter.sv - round-robin sharing of one multi-cycle FP adder between two requesters
// Optional WAIT_DONE watchdog enabled by defining FP_ARB_TIMEOUT_EN.
module fp_adder_arbiter #(
   parameter int Mantissa_Size = 23,
   parameter int Exponent_Size = 8,
   parameter int TIMEOUT       = 64
) (
   input logic               clk,
   input logic               rst_n,
   fp_adder_arbiter_if.slave bus
);
   localparam int W = Mantissa_Size + Exponent_Size + 1;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SETTLE,
      WAIT_DONE,
      RESP
   } state_t;

   state_t       state;
   state_t       state_nxt;
   logic         last_grant;
   logic         resp_id_q;
   logic         ovf_q;
   logic         err_q;
   logic [W-1:0] a_q;
   logic [W-1:0] b_q;
   logic [W-1:0] res_q;
   logic         grant0;
   logic         grant1;
   logic         ready0;
   logic         ready1;
   logic         done_hit;
   logic         timeout_hit;

   // On a tie the requester that did not win last time gets the adder.
   assign grant0 = bus.req0_valid && (!bus.req1_valid || last_grant);
   assign grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant);

   assign done_hit = (state == WAIT_DONE) && bus.add_done;

`ifdef FP_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT) + 1;
   logic [CW-1:0] wait_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wait_cnt <= '0;
      end else if (state == SETTLE) begin
         wait_cnt <= '0;
      end else if (state == WAIT_DONE) begin
         wait_cnt <= wait_cnt + CW'(1);
      end
   end

   // A done arriving on the last allowed cycle still wins over the error.
   assign timeout_hit = (state == WAIT_DONE) && !bus.add_done
                        && (wait_cnt == CW'(TIMEOUT - 1));
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT != 0);
   assign timeout_hit    = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      ready0    = 1'b0;
      ready1    = 1'b0;
      case (state)
         IDLE: begin
            ready0 = grant0;
            ready1 = grant1;
            if (grant0 || grant1) begin
               state_nxt = LOAD;
            end
         end
         LOAD:   state_nxt = SETTLE;
         // add_done may still reflect the previous operation here.
         SETTLE: state_nxt = WAIT_DONE;
         WAIT_DONE: begin
            if (done_hit || timeout_hit) begin
               state_nxt = RESP;
            end
         end
         RESP: begin
            if (bus.resp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         resp_id_q  <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         res_q      <= '0;
         ovf_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state <= state_nxt;
         if (ready0) begin
            a_q        <= bus.req0_a;
            b_q        <= bus.req0_b;
            resp_id_q  <= 1'b0;
            last_grant <= 1'b0;
         end else if (ready1) begin
            a_q        <= bus.req1_a;
            b_q        <= bus.req1_b;
            resp_id_q  <= 1'b1;
            last_grant <= 1'b1;
         end
         if (done_hit) begin
            res_q <= bus.add_result;
            ovf_q <= bus.add_overflow;
            err_q <= 1'b0;
         end else if (timeout_hit) begin
            res_q <= '0;
            ovf_q <= 1'b0;
            err_q <= 1'b1;
         end
      end
   end

   assign bus.req0_ready    = ready0;
   assign bus.req1_ready    = ready1;
   assign bus.resp_valid    = (state == RESP);
   assign bus.resp_id       = resp_id_q;
   assign bus.resp_result   = res_q;
   assign bus.resp_overflow = ovf_q;
   assign bus.resp_error    = err_q;
   assign bus.busy          = (state != IDLE);
   assign bus.add_enable    = 1'b1;
   assign bus.add_load      = (state == LOAD);
   assign bus.add_a         = a_q;
   assign bus.add_b         = b_q;
endmodule

// File: tb/tb_fp_adder_arbiter.sv
// tb/tb_fp_adder_arbiter.sv - scoreboard bench for fp_adder_arbiter with a behavioural adder stub
module tb_fp_adder_arbiter;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fp_adder_arbiter_if #(.W(W)) bus ();

   fp_adder_arbiter #(
      .Mantissa_Size(23),
      .Exponent_Size(8),
      .TIMEOUT(8)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Same-sign truncating FP32 add; result is {overflow, value}.
   function automatic logic [32:0] fp_add_ref(input logic [31:0] x, input logic [31:0] y);
      logic [31:0] a;
      logic [31:0] b;
      logic [7:0]  d;
      logic [24:0] ma;
      logic [24:0] mb;
      logic [24:0] s;
      logic [8:0]  e;
      if (y[30:23] > x[30:23]) begin
         a = y; b = x;
      end else begin
         a = x; b = y;
      end
      d  = a[30:23] - b[30:23];
      ma = {2'b01, a[22:0]};
      mb = {2'b01, b[22:0]};
      mb = (d > 8'd24) ? 25'd0 : (mb >> d);
      s  = ma + mb;
      e  = {1'b0, a[30:23]};
      if (s[24]) begin
         s = s >> 1;
         e = e + 9'd1;
      end
      if (e >= 9'd255) return {1'b1, a[31], 8'hFF, 23'h0};
      return {1'b0, a[31], e[7:0], s[22:0]};
   endfunction

   // Adder stub: done stays stale for one cycle after load, then rises after lat cycles.
   int          lat = 3;
   bit          stuck = 1'b0;
   int          stub_cnt = 0;
   logic [31:0] stub_a;
   logic [31:0] stub_b;

   always @(posedge clk) begin
      if (!rst_n) begin
         bus.add_done     <= 1'b0;
         bus.add_result   <= '0;
         bus.add_overflow <= 1'b0;
         stub_cnt         <= 0;
      end else if (bus.add_load) begin
         stub_a   <= bus.add_a;
         stub_b   <= bus.add_b;
         stub_cnt <= lat;
      end else if (stub_cnt != 0) begin
         stub_cnt     <= stub_cnt - 1;
         bus.add_done <= 1'b0;
         if (stub_cnt == 1 && !stuck) begin
            {bus.add_overflow, bus.add_result} <= fp_add_ref(stub_a, stub_b);
            bus.add_done <= 1'b1;
         end
      end
   end

   typedef struct packed {
      logic        id;
      logic [31:0] res;
      logic        ovf;
      logic        err;
   } resp_t;

   resp_t       sb[$];
   bit          acc_ids[$];
   int          cyc = 0;
   int          acc_cyc = 0;
   int          load_cyc = 0;
   int          rise_cyc = 0;
   logic [31:0] acc_a = '0;
   logic [31:0] acc_b = '0;
   logic        prev_valid = 1'b0;
   logic        last_id = 1'b0;
   logic [31:0] last_res = '0;
   logic        last_ovf = 1'b0;
   logic        last_err = 1'b0;

   always @(negedge clk) begin
      resp_t       e;
      resp_t       got;
      logic [32:0] r;
      cyc++;
      if (rst_n) begin
         check("ready_excl", {63'd0, bus.req0_ready & bus.req1_ready}, 64'd0);
         check("ready_busy", {63'd0, (bus.req0_ready | bus.req1_ready) & bus.busy}, 64'd0);
         if ((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready)) begin
            e.id  = bus.req1_ready;
            acc_a = bus.req1_ready ? bus.req1_a : bus.req0_a;
            acc_b = bus.req1_ready ? bus.req1_b : bus.req0_b;
            if (stuck) begin
               e.res = '0; e.ovf = 1'b0; e.err = 1'b1;
            end else begin
               r = fp_add_ref(acc_a, acc_b);
               e.res = r[31:0]; e.ovf = r[32]; e.err = 1'b0;
            end
            sb.push_back(e);
            acc_ids.push_back(e.id);
            acc_cyc = cyc;
         end
         if (bus.add_load) begin
            load_cyc = cyc;
            check("load_lat", 64'(cyc - acc_cyc), 64'd1);
            check("add_a", {32'd0, bus.add_a}, {32'd0, acc_a});
            check("add_b", {32'd0, bus.add_b}, {32'd0, acc_b});
         end
         if (bus.resp_valid && !prev_valid) begin
            rise_cyc = cyc;
            if (!stuck) check("resp_lat_max", {63'd0, (cyc - acc_cyc) <= 12}, 64'd1);
         end
         if (bus.resp_valid && bus.resp_ready) begin
            if (sb.size() == 0) begin
               check("sb_empty", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               check("resp_id", {63'd0, bus.resp_id}, {63'd0, e.id});
               check("resp_result", {32'd0, bus.resp_result}, {32'd0, e.res});
               check("resp_overflow", {63'd0, bus.resp_overflow}, {63'd0, e.ovf});
               check("resp_error", {63'd0, bus.resp_error}, {63'd0, e.err});
               got = '{id: bus.resp_id, res: bus.resp_result, ovf: bus.resp_overflow, err: bus.resp_error};
               last_id  = got.id;
               last_res = got.res;
               last_ovf = got.ovf;
               last_err = got.err;
            end
         end
         prev_valid = bus.resp_valid;
      end else begin
         prev_valid = 1'b0;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rand_op();
      return {1'b0, 8'($urandom_range(64, 190)), 23'($urandom)};
   endfunction

   task automatic send(input bit id, input logic [31:0] a, input logic [31:0] b);
      bit ok;
      ok = 1'b0;
      if (id) begin
         bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1;
      end else begin
         bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1;
      end
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk);
         ok = id ? bus.req1_ready : bus.req0_ready;
      end
      if (!ok) check("send_timeout", 64'd1, 64'd0);
      @(posedge clk);
      #1;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
   endtask

   task automatic wait_drain();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         ok = (sb.size() == 0) && !bus.busy;
      end
      if (!ok) check("drain_timeout", 64'd1, 64'd0);
      tick(1);
   endtask

   initial begin
      int n;
      bit r0;
      bit r1;
      bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
      bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
      bus.resp_ready = 1'b0;

      // reset state
      tick(2);
      @(negedge clk);
      check("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
      check("rst_busy", {63'd0, bus.busy}, 64'd0);
      check("rst_add_load", {63'd0, bus.add_load}, 64'd0);
      check("rst_add_enable", {63'd0, bus.add_enable}, 64'd1);
      check("rst_add_a", {32'd0, bus.add_a}, 64'd0);
      check("rst_resp_result", {32'd0, bus.resp_result}, 64'd0);
      check("rst_resp_error", {63'd0, bus.resp_error}, 64'd0);
      check("rst_ready", {62'd0, bus.req0_ready, bus.req1_ready}, 64'd0);
      tick(1);
      rst_n = 1'b1;
      bus.resp_ready = 1'b1;
      tick(1);

      // single request and overflow pass-through
      lat = 3;
      send(1'b0, 32'h3E7E3B76, 32'h3E7E3B78);
      wait_drain();
      check("single_result", {32'd0, last_res}, 64'h3EFE3B77);
      check("single_id", {63'd0, last_id}, 64'd0);
      check("single_ovf", {63'd0, last_ovf}, 64'd0);
      lat = 6;
      send(1'b1, 32'h7FFFFFFF, 32'h7F800001);
      wait_drain();
      check("ovf_id", {63'd0, last_id}, 64'd1);
      check("ovf_flag", {63'd0, last_ovf}, 64'd1);
      check("ovf_error", {63'd0, last_err}, 64'd0);

      // random single requests with varying adder latency
      for (int k = 0; k < 6; k++) begin
         lat = $urandom_range(1, 9);
         send(1'($urandom_range(0, 1)), rand_op(), rand_op());
         wait_drain();
      end

      // contention from reset: grants must alternate starting with requester 0
      rst_n = 1'b0;
      bus.req0_valid = 1'b1; bus.req0_a = rand_op(); bus.req0_b = rand_op();
      bus.req1_valid = 1'b1; bus.req1_a = rand_op(); bus.req1_b = rand_op();
      tick(1);
      sb.delete();
      acc_ids.delete();
      rst_n = 1'b1;
      lat = 4;
      n = 0;
      for (int i = 0; i < 200 && n < 4; i++) begin
         @(negedge clk);
         r0 = bus.req0_ready;
         r1 = bus.req1_ready;
         @(posedge clk);
         #1;
         if (r0) begin bus.req0_a = rand_op(); bus.req0_b = rand_op(); n++; end
         if (r1) begin bus.req1_a = rand_op(); bus.req1_b = rand_op(); n++; end
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      wait_drain();
      check("cont_count", 64'(acc_ids.size()), 64'd4);
      for (int i = 0; i < 4 && i < acc_ids.size(); i++) begin
         check($sformatf("cont_grant%0d", i), {63'd0, acc_ids[i]}, 64'(i % 2));
      end

      // back-pressure: response held, no grants, then round robin resumes
      bus.resp_ready = 1'b0;
      lat = 5;
      send(1'b0, rand_op(), rand_op());
      n = 0;
      for (int i = 0; i < 40 && !bus.resp_valid; i++) tick(1);
      bus.req0_valid = 1'b1; bus.req0_a = rand_op(); bus.req0_b = rand_op();
      bus.req1_valid = 1'b1; bus.req1_a = rand_op(); bus.req1_b = rand_op();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("bp_valid", {63'd0, bus.resp_valid}, 64'd1);
         check("bp_id", {63'd0, bus.resp_id}, 64'd0);
         if (sb.size() != 0) check("bp_result", {32'd0, bus.resp_result}, {32'd0, sb[0].res});
         check("bp_ready", {62'd0, bus.req0_ready, bus.req1_ready}, 64'd0);
         check("bp_load", {63'd0, bus.add_load}, 64'd0);
      end
      tick(1);
      bus.resp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("bp_idle_busy", {63'd0, bus.busy}, 64'd0);
      check("bp_rr_ready1", {63'd0, bus.req1_ready}, 64'd1);
      check("bp_rr_ready0", {63'd0, bus.req0_ready}, 64'd0);
      @(posedge clk);
      #1;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      wait_drain();

      // reset while waiting for done, then the tie goes to requester 0
      lat = 10;
      send(1'b0, rand_op(), rand_op());
      tick(3);
      @(negedge clk);
      check("mid_busy", {63'd0, bus.busy}, 64'd1);
      check("mid_no_resp", {63'd0, bus.resp_valid}, 64'd0);
      tick(1);
      rst_n = 1'b0;
      sb.delete();
      tick(1);
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_busy", {63'd0, bus.busy}, 64'd0);
      check("abort_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
      tick(1);
      acc_ids.delete();
      lat = 3;
      bus.req0_valid = 1'b1; bus.req0_a = rand_op(); bus.req0_b = rand_op();
      bus.req1_valid = 1'b1; bus.req1_a = rand_op(); bus.req1_b = rand_op();
      @(negedge clk);
      check("abort_tie_ready0", {63'd0, bus.req0_ready}, 64'd1);
      @(posedge clk);
      #1;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      wait_drain();
      check("abort_tie_id", (acc_ids.size() > 0) ? {63'd0, acc_ids[0]} : 64'd9, 64'd0);

`ifdef FP_ARB_TIMEOUT_EN
      // stuck adder: error response 8 cycles after entering WAIT_DONE
      stuck = 1'b1;
      send(1'b1, rand_op(), rand_op());
      wait_drain();
      check("tmo_error", {63'd0, last_err}, 64'd1);
      check("tmo_result", {32'd0, last_res}, 64'd0);
      check("tmo_cycles", 64'(rise_cyc - (load_cyc + 2)), 64'd8);
      stuck = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout got=0x0 exp=0x1");
      $fatal(1, "global timeout");
   end
endmodule
